tmem_responder: RTL and testbench
=================================

Name: tmem_responder

Overview:
- Responder end of the CPU's tagged-memory bus. Accepts the multiplexed address/data strobes that the cpu block drives (ad, tag, astb, atomic, rd, wr).
- Returns tagged 64-bit words from an internal 2^ADDR_W x (64+8) store.
- Adds programmable wait states and an atomic read-modify-write sequence, so the bench and the FPGA top can exercise bus-timing and protocol-error paths that the plain tagged RAM never produces.

Parameters:
- ADDR_W, 20, word-address width; store depth 2^ADDR_W words.
- WAIT, 0, extra cycles between read acceptance and data valid (0..15).
- TIMEOUT, 64, cycles allowed between address strobe and rd/wr (only with TMEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- i_ad  in  64  address (astb cycle) or write data (wr cycle).
- i_tag  in  8  write tag.
- i_astb  in  1  address strobe.
- i_atomic  in  1  sampled with i_astb; marks read-modify-write.
- i_rd  in  1  read request.
- i_wr  in  1  write request.
- o_data  out  64  read data.
- o_tag  out  8  read tag.
- o_valid  out  1  one-cycle pulse, o_data/o_tag valid.
- o_busy  out  1  high in RDWAIT and LOCKED.
- o_err  out  1  one-cycle protocol-error pulse.
- o_timeout  out  1  one-cycle timeout pulse (tied 0 without macro).

Behaviour:
- Reset (async): state IDLE. o_data=0, o_tag=0, o_valid=0, o_busy=0, o_err=0, o_timeout=0, waddr=0, lock=0, wait counter=0. Store contents are not reset.
- States: IDLE, ADDR, RDWAIT, LOCKED.
- IDLE:
  - i_astb=1 → waddr<=i_ad[ADDR_W-1:0], lock_req<=i_atomic, go ADDR.
  - i_rd or i_wr without astb → o_err pulse, stay IDLE.
  - astb together with rd or wr in the same cycle → o_err pulse, stay IDLE.
- ADDR:
  - i_astb=1 re-latches the address (last strobe wins), no error.
  - i_rd=1 & i_wr=0 → start read, counter<=WAIT, go RDWAIT.
  - i_wr=1 & i_rd=0 → store[waddr]<={i_tag,i_ad} at this edge, go IDLE.
  - i_rd & i_wr together → o_err pulse, no access, go IDLE.
- RDWAIT:
  - When counter==0: o_data/o_tag<=store[waddr], o_valid=1 for one cycle. Go LOCKED if lock_req, else IDLE.
  - Otherwise decrement the counter.
  - Any astb/rd/wr here → o_err pulse and is ignored; the read completes normally.
  - Read latency is WAIT+1 cycles after the rd cycle: o_valid is high in the cycle after the edge that is WAIT+1 edges past the rd edge.
- LOCKED:
  - i_wr=1 → write to the same waddr (no new astb required), go IDLE.
  - i_astb or i_rd → o_err pulse, lock dropped, go IDLE; the new strobe is not latched.
- o_data/o_tag hold their value until the next read completes.
- Writes never disturb o_data.
- A read of an address written in the previous cycle returns the new value.
- Address bits above ADDR_W are ignored (wrap-around).
- Reset asserted mid-read: o_valid never pulses and the store is unchanged.
- Reset asserted in LOCKED: lock cleared.

Optional Feature:
TMEM_TIMEOUT_EN:
- Defined: a counter runs in ADDR and LOCKED. After TIMEOUT cycles with no qualifying rd/wr, pulse o_timeout for one cycle, clear lock, go IDLE. The counter restarts on each re-latching astb. This feeds the CPU's RAM time-out interrupt path (int12/13).
- Not defined: no counter, o_timeout tied 0, ADDR/LOCKED wait indefinitely.

Test Plan:
1. WAIT=0: astb i_ad=0x00123, then wr i_ad=0x0123456789ABCDEF i_tag=0x35; then astb 0x00123, rd → o_valid exactly 1 cycle after rd, o_data=0x0123456789ABCDEF, o_tag=0x35, o_err never set.
2. WAIT=3: read of 0x00007 preloaded 0xFFFF...F/0x3F → o_busy high 4 cycles, o_valid at rd+4; an extra astb during RDWAIT gives o_err=1 and the data is unchanged.
3. Atomic: astb 0x10 with i_atomic=1, rd → data; then wr 0xAA/tag 0x01 without astb → a later read of 0x10 returns 0xAA/0x01; astb in LOCKED instead → o_err, location keeps its old value.
4. Protocol errors: rd in IDLE, rd+wr in ADDR, astb+wr in IDLE → o_err pulses each time, store unchanged, state IDLE (next astb/rd works).
5. Reset asserted 1 cycle after rd with WAIT=5 → all outputs 0 immediately, no o_valid afterwards, the subsequent normal read returns the preloaded data.
6. With TMEM_TIMEOUT_EN, TIMEOUT=8: astb 0x20 then idle 8 cycles → o_timeout pulse, back in IDLE, a late rd gives o_err; without the macro, o_timeout stays 0 and the late rd succeeds.

Source files
------------

// File: rtl/tmem_responder.sv
// tmem_responder: tagged-memory bus responder with programmable read wait states and an atomic RMW lock.
// Define TMEM_TIMEOUT_EN to abort ADDR/LOCKED after TIMEOUT quiet cycles with an o_timeout pulse.
module tmem_responder #(
    parameter int ADDR_W  = 20,
    parameter int WAIT    = 0,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] i_ad,
    input  logic [7:0]  i_tag,
    input  logic        i_astb,
    input  logic        i_atomic,
    input  logic        i_rd,
    input  logic        i_wr,
    output logic [63:0] o_data,
    output logic [7:0]  o_tag,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_timeout
);
    typedef enum logic [1:0] {IDLE, ADDR, RDWAIT, LOCKED} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] waddr, waddr_n;
    logic lock, lock_n;
    logic [3:0] cnt, cnt_n;
    logic err_n, valid_n, we, quiet, expire;
    logic [71:0] mem [0:(2**ADDR_W)-1];

    assign o_busy = (state == RDWAIT) || (state == LOCKED);
    assign quiet  = !(i_astb || i_rd || i_wr);

`ifdef TMEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_n;
    logic tout_n;
    assign expire = (tcnt == TW'(TIMEOUT - 1));
    // Any strobe in ADDR/LOCKED either leaves the state or re-latches, so the count restarts from zero.
    always_comb begin
        tcnt_n = '0;
        tout_n = 1'b0;
        if ((state == ADDR || state == LOCKED) && quiet) begin
            tout_n = expire;
            tcnt_n = expire ? '0 : tcnt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt      <= '0;
            o_timeout <= 1'b0;
        end else begin
            tcnt      <= tcnt_n;
            o_timeout <= tout_n;
        end
    end
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        waddr_n = waddr;
        lock_n  = lock;
        cnt_n   = cnt;
        err_n   = 1'b0;
        valid_n = 1'b0;
        we      = 1'b0;
        case (state)
            IDLE: begin
                if (i_astb && !i_rd && !i_wr) begin
                    waddr_n = i_ad[ADDR_W-1:0];
                    lock_n  = i_atomic;
                    state_n = ADDR;
                end else if (!quiet) begin
                    err_n = 1'b1;
                end
            end
            ADDR: begin
                if (i_astb) begin
                    waddr_n = i_ad[ADDR_W-1:0];
                    lock_n  = i_atomic;
                end else if (i_rd && i_wr) begin
                    err_n   = 1'b1;
                    lock_n  = 1'b0;
                    state_n = IDLE;
                end else if (i_rd) begin
                    cnt_n   = 4'(WAIT);
                    state_n = RDWAIT;
                end else if (i_wr) begin
                    we      = 1'b1;
                    lock_n  = 1'b0;
                    state_n = IDLE;
                end else if (expire) begin
                    lock_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            RDWAIT: begin
                err_n = !quiet;
                if (cnt == 4'd0) begin
                    valid_n = 1'b1;
                    state_n = lock ? LOCKED : IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            LOCKED: begin
                if (i_astb || i_rd) begin
                    err_n   = 1'b1;
                    lock_n  = 1'b0;
                    state_n = IDLE;
                end else if (i_wr) begin
                    we      = 1'b1;
                    lock_n  = 1'b0;
                    state_n = IDLE;
                end else if (expire) begin
                    lock_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            waddr   <= '0;
            lock    <= 1'b0;
            cnt     <= '0;
            o_data  <= '0;
            o_tag   <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state   <= state_n;
            waddr   <= waddr_n;
            lock    <= lock_n;
            cnt     <= cnt_n;
            o_valid <= valid_n;
            o_err   <= err_n;
            if (valid_n) {o_tag, o_data} <= mem[waddr];
        end
    end

    // Store has no reset; writes only happen in ADDR/LOCKED, which reset forces away from.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= {i_tag, i_ad};
    end
endmodule

// File: tb/tb_tmem_responder.sv
// tb_tmem_responder: directed checks of three responders (WAIT 0/3/5) sharing clk and reset.
module tb_tmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [63:0] ad [3];
    logic [7:0] tag [3];
    logic astb [3], atomic [3], rd [3], wr [3];
    logic [63:0] data [3];
    logic [7:0] otag [3];
    logic valid [3], busy [3], err [3], tout [3];
    int s = 0;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tmem_responder #(
            .ADDR_W(g == 0 ? 20 : 8),
            .WAIT(g == 0 ? 0 : (g == 1 ? 3 : 5)),
            .TIMEOUT(8)
        ) u_dut (
            .clk(clk), .reset(reset), .i_ad(ad[g]), .i_tag(tag[g]), .i_astb(astb[g]),
            .i_atomic(atomic[g]), .i_rd(rd[g]), .i_wr(wr[g]), .o_data(data[g]), .o_tag(otag[g]),
            .o_valid(valid[g]), .o_busy(busy[g]), .o_err(err[g]), .o_timeout(tout[g])
        );
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic at, input logic r, input logic w,
                         input logic [63:0] d, input logic [7:0] t);
        astb[s] = a; atomic[s] = at; rd[s] = r; wr[s] = w; ad[s] = d; tag[s] = t;
        tick();
        astb[s] = 1'b0; atomic[s] = 1'b0; rd[s] = 1'b0; wr[s] = 1'b0;
    endtask

    task automatic write_word(input logic [63:0] a, input logic [63:0] d, input logic [7:0] t);
        drive(1'b1, 1'b0, 1'b0, 1'b0, a, 8'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, d, t);
    endtask

    task automatic read_word(input logic [63:0] a, input logic at, output logic [71:0] q, output int lat);
        drive(1'b1, at, 1'b0, 1'b0, a, 8'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        lat = 0;
        while (!valid[s] && lat < 20) begin
            tick();
            lat++;
        end
        q = {otag[s], data[s]};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [71:0] q;
        int lat, bcnt, vpos, n, tpos;
        logic eseen, vseen;
        for (int i = 0; i < 3; i++) begin
            ad[i] = '0; tag[i] = '0; astb[i] = 1'b0; atomic[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
        end
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            check("reset_data", {otag[i], data[i]}, 72'h0);
            check("reset_flags", {valid[i], busy[i], err[i], tout[i]}, 4'h0);
        end
        reset = 1'b0;
        tick();

        // WAIT=0 write then read, wrap-around and write-does-not-disturb
        s = 0;
        write_word(64'h123, 64'h0123456789ABCDEF, 8'h35);
        check("t1_wr_err", err[0], 1'b0);
        read_word(64'h123, 1'b0, q, lat);
        check("t1_lat", lat, 1);
        check("t1_data", q, {8'h35, 64'h0123456789ABCDEF});
        check("t1_err", err[0], 1'b0);
        tick();
        check("t1_pulse", valid[0], 1'b0);
        read_word(64'hFFFF_FFFF_FFF0_0123, 1'b0, q, lat);
        check("t1_wrap", q, {8'h35, 64'h0123456789ABCDEF});
        write_word(64'h456, 64'h1111, 8'h22);
        check("t1_wr_keeps_data", {otag[0], data[0]}, {8'h35, 64'h0123456789ABCDEF});

        // WAIT=3 with a stray strobe during RDWAIT
        s = 1;
        write_word(64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h3F);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h7, 8'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        bcnt = busy[1] ? 1 : 0;
        vpos = 0;
        eseen = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h99, 8'h0);
            else tick();
            if (k == 1) eseen = err[1];
            if (busy[1]) bcnt++;
            if (valid[1] && vpos == 0) vpos = k;
        end
        check("t2_busy_cycles", bcnt, 4);
        check("t2_valid_pos", vpos, 4);
        check("t2_stray_err", eseen, 1'b1);
        check("t2_data", {otag[1], data[1]}, {8'h3F, 64'hFFFF_FFFF_FFFF_FFFF});
        read_word(64'h7, 1'b0, q, lat);
        check("t2_lat", lat, 4);

        // atomic read-modify-write, and strobe in LOCKED
        s = 0;
        write_word(64'h10, 64'h1234, 8'h77);
        read_word(64'h10, 1'b1, q, lat);
        check("t3_rmw_read", q, {8'h77, 64'h1234});
        check("t3_locked_busy", busy[0], 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hAA, 8'h01);
        check("t3_lock_wr_err", err[0], 1'b0);
        check("t3_unlock_busy", busy[0], 1'b0);
        read_word(64'h10, 1'b0, q, lat);
        check("t3_rmw_result", q, {8'h01, 64'hAA});
        read_word(64'h10, 1'b1, q, lat);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h20, 8'h0);
        check("t3_lock_astb_err", err[0], 1'b1);
        check("t3_lock_dropped", busy[0], 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hBB, 8'h02);
        check("t3_not_latched", err[0], 1'b1);
        read_word(64'h10, 1'b0, q, lat);
        check("t3_kept", q, {8'h01, 64'hAA});

        // protocol errors
        drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        check("t4_rd_idle", err[0], 1'b1);
        tick();
        check("t4_err_pulse", err[0], 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h123, 8'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'hDEAD, 8'h66);
        check("t4_rdwr", err[0], 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h123, 8'h66);
        check("t4_astb_wr", err[0], 1'b1);
        check("t4_idle_busy", busy[0], 1'b0);
        read_word(64'h123, 1'b0, q, lat);
        check("t4_lat", lat, 1);
        check("t4_store", q, {8'h35, 64'h0123456789ABCDEF});

        // reset in LOCKED clears the lock
        read_word(64'h10, 1'b1, q, lat);
        check("t5_locked", busy[0], 1'b1);
        reset = 1'b1;
        #1;
        check("t5_lock_rst_busy", busy[0], 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hCC, 8'h03);
        check("t5_lock_cleared", err[0], 1'b1);
        read_word(64'h10, 1'b0, q, lat);
        check("t5_lock_store", q, {8'h01, 64'hAA});

        // reset mid-read with WAIT=5
        s = 2;
        write_word(64'h33, 64'hCAFE, 8'h5A);
        read_word(64'h33, 1'b0, q, lat);
        check("t5_pre_lat", lat, 6);
        check("t5_pre_data", q, {8'h5A, 64'hCAFE});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h33, 8'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
        tick();
        reset = 1'b1;
        #1;
        check("t5_rst_data", {otag[2], data[2]}, 72'h0);
        check("t5_rst_flags", {valid[2], busy[2], err[2], tout[2]}, 4'h0);
        tick();
        reset = 1'b0;
        vseen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (valid[2]) vseen = 1'b1;
        end
        check("t5_no_valid", vseen, 1'b0);
        read_word(64'h33, 1'b0, q, lat);
        check("t5_post_lat", lat, 6);
        check("t5_post_data", q, {8'h5A, 64'hCAFE});

        // address-phase timeout
        s = 1;
        write_word(64'h20, 64'hBEEF, 8'h11);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h20, 8'h0);
        n = 0;
        tpos = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (tout[1]) begin
                n++;
                tpos = k;
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 8'h0);
`ifdef TMEM_TIMEOUT_EN
        check("t6_tout_count", n, 1);
        check("t6_tout_pos", tpos, 8);
        check("t6_late_rd_err", err[1], 1'b1);
        vseen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (valid[1]) vseen = 1'b1;
        end
        check("t6_no_valid", vseen, 1'b0);
`else
        check("t6_tout_count", n, 0);
        check("t6_late_rd_err", err[1], 1'b0);
        lat = 0;
        while (!valid[1] && lat < 20) begin
            tick();
            lat++;
        end
        check("t6_late_lat", lat, 4);
        check("t6_late_data", {otag[1], data[1]}, {8'h11, 64'hBEEF});
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
